// File: rtl/switch_debounce_bank_pkg.sv
// Shared constants and types for the Go Board push-button conditioning path.
// The LED stages import the same values so the channel count and debounce time agree.
package switch_debounce_bank_pkg;

   localparam int NUM_SW                    = 4;
   localparam int DEBOUNCE_LIMIT_25MHZ_10MS = 250000;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } filt_out_t;

   // A limit of 2 still needs one counter bit to hold the value LIMIT-1.
   function automatic int count_width(input int limit);
      return (limit > 2) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch channel: 2-FF synchronizer, stable-time filter and registered edge strobes.
// A new level is accepted only after it has been seen for LIMIT consecutive cycles.
module debounce_filter
   import switch_debounce_bank_pkg::*;
#(
   parameter int LIMIT = DEBOUNCE_LIMIT_25MHZ_10MS
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW   = count_width(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   filt_out_t     out_q;
   filt_out_t     out_next;

   // synchronizer chain; raw is sampled nowhere else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // filter next state; acceptance at LAST also clears the count, so it never wraps
   always_comb begin
      count_next    = count;
      out_next      = out_q;
      out_next.rise = 1'b0;
      out_next.fall = 1'b0;
      if (s2 == out_q.level) begin
         count_next = {CW{1'b0}};
      end else if (count == LAST) begin
         count_next     = {CW{1'b0}};
         out_next.level = s2;
         out_next.rise  = s2;
         out_next.fall  = ~s2;
      end else begin
         count_next = count + CW'(1);
      end
   end

   // filter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= {CW{1'b0}};
         out_q <= '0;
      end else begin
         count <= count_next;
         out_q <= out_next;
      end
   end

   assign level = out_q.level;
   assign rise  = out_q.rise;
   assign fall  = out_q.fall;

   debounce_filter_chk #(
      .LIMIT (LIMIT),
      .CW    (CW)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .count (count),
      .rise  (out_q.rise),
      .fall  (out_q.fall)
   );

endmodule

// File: rtl/debounce_filter_chk.sv
// Property checks for one debounce channel: the stable-time counter stays within range,
// and the rise and fall strobes are never high together.
module debounce_filter_chk #(
   parameter int LIMIT = 4,
   parameter int CW    = 2
) (
   input logic          clk,
   input logic          rst,
   input logic [CW-1:0] count,
   input logic          rise,
   input logic          fall
);

   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   count_bound: assert property (@(posedge clk) disable iff (rst) count <= LAST);

   strobe_excl: assert property (@(posedge clk) disable iff (rst) !(rise && fall));

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of independent debounce channels for the board push-buttons.
// Each channel is a self-contained debounce_filter; this level only fans the pins out.
module switch_debounce_bank #(
   parameter int NUM_SW         = switch_debounce_bank_pkg::NUM_SW,
   parameter int DEBOUNCE_LIMIT = switch_debounce_bank_pkg::DEBOUNCE_LIMIT_25MHZ_10MS
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [NUM_SW-1:0] i_Switch,
   output logic [NUM_SW-1:0] o_Switch,
   output logic [NUM_SW-1:0] o_Rise,
   output logic [NUM_SW-1:0] o_Fall
);

   for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
      debounce_filter #(
         .LIMIT (DEBOUNCE_LIMIT)
      ) u_filter (
         .clk   (i_Clk),
         .rst   (i_Rst),
         .raw   (i_Switch[n]),
         .level (o_Switch[n]),
         .rise  (o_Rise[n]),
         .fall  (o_Fall[n])
      );
   end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Scoreboard bench for switch_debounce_bank at LIMIT 4, 2 and 5.
// Stimulus queues the expected output change for the cycle it is due; a negedge monitor compares.
module tb_switch_debounce_bank;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] level;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw [3];
   logic [3:0] lvl0, rise0, fall0;
   logic [3:0] lvl1, rise1, fall1;
   logic [3:0] lvl2, rise2, fall2;

   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   ev_t        sb [3][$];
   logic [3:0] stim_lvl [3];
   logic [3:0] mon_lvl [3];

   switch_debounce_bank #(.NUM_SW(4), .DEBOUNCE_LIMIT(4)) dut0 (
      .i_Clk(clk), .i_Rst(rst), .i_Switch(sw[0]),
      .o_Switch(lvl0), .o_Rise(rise0), .o_Fall(fall0));

   switch_debounce_bank #(.NUM_SW(4), .DEBOUNCE_LIMIT(2)) dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_Switch(sw[1]),
      .o_Switch(lvl1), .o_Rise(rise1), .o_Fall(fall1));

   switch_debounce_bank #(.NUM_SW(4), .DEBOUNCE_LIMIT(5)) dut2 (
      .i_Clk(clk), .i_Rst(rst), .i_Switch(sw[2]),
      .o_Switch(lvl2), .o_Rise(rise2), .o_Fall(fall2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lim_of(input int d);
      case (d)
         0:       return 4;
         1:       return 2;
         default: return 5;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge: the new level is first sampled on the next posedge (N),
   // so the output changes after edge N+LIMIT+1.
   task automatic expect_change(input int d, input int ch, input logic v);
      ev_t e;
      int  at;
      at           = cyc + lim_of(d) + 2;
      sw[d][ch]    = v;
      stim_lvl[d][ch] = v;
      if (sb[d].size() > 0 && sb[d][sb[d].size()-1].cyc == at) begin
         e = sb[d][sb[d].size()-1];
         void'(sb[d].pop_back());
      end else begin
         e.cyc  = at;
         e.rise = 4'h0;
         e.fall = 4'h0;
      end
      if (v) e.rise[ch] = 1'b1;
      else   e.fall[ch] = 1'b1;
      e.level = stim_lvl[d];
      sb[d].push_back(e);
   endtask

   task automatic mon(input int d, input logic [3:0] l, input logic [3:0] r, input logic [3:0] f);
      ev_t        e;
      logic [3:0] el, er, ef;
      el = 4'h0;
      er = 4'h0;
      ef = 4'h0;
      if (rst) begin
         mon_lvl[d] = 4'h0;
      end else begin
         while (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
            e = sb[d].pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event dut%0d: due cyc %0d still pending at cyc %0d (rise=%h fall=%h)",
                     d, e.cyc, cyc, e.rise, e.fall);
         end
         if (sb[d].size() > 0 && sb[d][0].cyc == cyc) begin
            e = sb[d].pop_front();
            mon_lvl[d] = e.level;
            er = e.rise;
            ef = e.fall;
         end
         el = mon_lvl[d];
      end
      checks++;
      if ({l, r, f} !== {el, er, ef}) begin
         errors++;
         $display("FAIL outputs dut%0d cyc %0d: got sw=%h rise=%h fall=%h, expected sw=%h rise=%h fall=%h",
                  d, cyc, l, r, f, el, er, ef);
      end
   endtask

   always @(negedge clk) begin
      mon(0, lvl0, rise0, fall0);
      mon(1, lvl1, rise1, fall1);
      mon(2, lvl2, rise2, fall2);
   end

   task automatic check_zero(input string name);
      checks++;
      if ({lvl0, rise0, fall0, lvl1, rise1, fall1, lvl2, rise2, fall2} !== 36'h0) begin
         errors++;
         $display("FAIL %s: got dut0 %h/%h/%h dut1 %h/%h/%h dut2 %h/%h/%h, expected all zero",
                  name, lvl0, rise0, fall0, lvl1, rise1, fall1, lvl2, rise2, fall2);
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         sw[d]       = 4'h0;
         stim_lvl[d] = 4'h0;
         mon_lvl[d]  = 4'h0;
      end
      tick(3);
      check_zero("reset_state");
      rst = 1'b0;
      tick(4);

      // clean press on ch0
      expect_change(0, 0, 1'b1);
      tick(12);

      // bounce on ch1: 2-cycle highs never reach LIMIT=4, final hold is accepted
      sw[0][1] = 1'b1; tick(2);
      sw[0][1] = 1'b0; tick(2);
      sw[0][1] = 1'b1; tick(2);
      sw[0][1] = 1'b0; tick(2);
      expect_change(0, 1, 1'b1);
      tick(12);

      // glitch on ch2 lasting LIMIT-1 cycles
      sw[0][2] = 1'b1; tick(3);
      sw[0][2] = 1'b0;
      tick(12);

      // release ch0 and press ch3 two cycles later
      expect_change(0, 0, 1'b0);
      tick(2);
      expect_change(0, 3, 1'b1);
      tick(12);

      // minimum and non-power-of-two limits
      for (int d = 1; d < 3; d++) begin
         expect_change(d, 0, 1'b1);
         tick(12);
         sw[d][1] = 1'b1; tick(lim_of(d) - 1);
         sw[d][1] = 1'b0;
         tick(12);
         expect_change(d, 0, 1'b0);
         expect_change(d, 2, 1'b1);
         tick(12);
      end

      // reset mid-count with all switches pressed
      sw[0] = 4'hF;
      tick(4);
      #2;
      rst = 1'b1;
      sw[1] = 4'hF;
      sw[2] = 4'hF;
      for (int d = 0; d < 3; d++) stim_lvl[d] = 4'h0;
      #1;
      check_zero("async_reset");
      tick(3);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         for (int ch = 0; ch < 4; ch++) expect_change(d, ch, 1'b1);
      end
      tick(15);

      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sb[d].size() != 0) begin
            errors++;
            $display("FAIL drained dut%0d: %0d events left, expected 0", d, sb[d].size());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
